// File: rtl/hilo_muldiv.sv
// hilo_muldiv: HI/LO register pair fed by a sequential radix-2 Booth multiplier
// and a restoring divider; also serves MTHI/MTLO writes.
module hilo_muldiv #(
    parameter int unsigned WWidth = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [WWidth-1:0] a,
    input  logic [WWidth-1:0] b,
    output logic              busy,
    output logic              done,
    output logic              divZero,
    output logic [WWidth-1:0] hi,
    output logic [WWidth-1:0] lo
);

    localparam int unsigned AccWidth = 2 * (WWidth + 1) + 1;
    localparam int unsigned CntWidth = $clog2(WWidth + 2);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} stateT;

    stateT               state;
    logic [CntWidth-1:0] cnt;
    // {partial product, multiplier, previous booth bit}
    logic [AccWidth-1:0] acc;
    logic [WWidth:0]     mcand;
    logic [WWidth-1:0]   rem;
    logic [WWidth-1:0]   quo;
    logic [WWidth-1:0]   dvsr;
    logic                qNeg;
    logic                rNeg;
    logic                divByZero;

    logic [WWidth:0]     boothSum;
    logic [AccWidth-1:0] accNext;
    logic [WWidth:0]     shifted;
    logic [WWidth-1:0]   diff;
    logic [WWidth-1:0]   remNext;
    logic [WWidth-1:0]   quoNext;
    logic                fits;

    // One Booth step: add/sub the multiplicand per the booth pair, then arithmetic shift right
    always_comb begin
        boothSum = acc[AccWidth-1 -: (WWidth + 1)];
        case (acc[1:0])
            2'b01:   boothSum = acc[AccWidth-1 -: (WWidth + 1)] + mcand;
            2'b10:   boothSum = acc[AccWidth-1 -: (WWidth + 1)] - mcand;
            default: ;
        endcase
        accNext = {boothSum[WWidth], boothSum, acc[WWidth+1:1]};
    end

    // One restoring-division step: shift in the next dividend bit and trial-subtract
    always_comb begin
        shifted = {rem, quo[WWidth-1]};
        fits    = shifted >= {1'b0, dvsr};
        // When the trial fits, the true difference is below the divisor so W bits suffice
        diff    = shifted[WWidth-1:0] - dvsr;
        remNext = fits ? diff : shifted[WWidth-1:0];
        quoNext = {quo[WWidth-2:0], fits};
    end

    // Control FSM, datapath registers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            rem       <= '0;
            quo       <= '0;
            dvsr      <= '0;
            qNeg      <= 1'b0;
            rNeg      <= 1'b0;
            divByZero <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            divZero   <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            done    <= 1'b0;
            divZero <= 1'b0;
            case (state)
                StIdle: begin
                    if (start) begin
                        case (op)
                            3'b000, 3'b001: begin
                                // op[0] selects zero-extension (MULTU)
                                mcand <= {~op[0] & a[WWidth-1], a};
                                acc   <= {{(WWidth + 1){1'b0}}, ~op[0] & b[WWidth-1], b, 1'b0};
                                cnt   <= '0;
                                busy  <= 1'b1;
                                state <= StMul;
                            end
                            3'b010, 3'b011: begin
                                rem       <= '0;
                                quo       <= (~op[0] & a[WWidth-1]) ? -a : a;
                                dvsr      <= (~op[0] & b[WWidth-1]) ? -b : b;
                                qNeg      <= ~op[0] & (a[WWidth-1] ^ b[WWidth-1]);
                                rNeg      <= ~op[0] & a[WWidth-1];
                                divByZero <= (b == '0);
                                cnt       <= '0;
                                busy      <= 1'b1;
                                // Zero divisor skips the iterations and only reports
                                state     <= (b == '0) ? StFix : StDiv;
                            end
                            3'b100:  hi <= a;
                            3'b101:  lo <= a;
                            default: ;
                        endcase
                    end
                end
                StMul: begin
                    acc <= accNext;
                    cnt <= cnt + 1'b1;
                    if (cnt == CntWidth'(WWidth)) begin
                        hi    <= accNext[2*WWidth:WWidth+1];
                        lo    <= accNext[WWidth:1];
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= StIdle;
                    end
                end
                StDiv: begin
                    rem <= remNext;
                    quo <= quoNext;
                    cnt <= cnt + 1'b1;
                    if (cnt == CntWidth'(WWidth - 1)) begin
                        state <= StFix;
                    end
                end
                StFix: begin
                    if (!divByZero) begin
                        lo <= qNeg ? -quo : quo;
                        hi <= rNeg ? -rem : rem;
                    end
                    divZero   <= divByZero;
                    divByZero <= 1'b0;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
